// File: rtl/mac_reg_pkg.sv
// MAC CPU register bus master: register map, FSM states and init table.
// The init table is only referenced when MAC_REG_INIT_EN is defined.
package mac_reg_pkg;

  localparam logic [6:0] REG_TX_HWMARK              = 7'd0;
  localparam logic [6:0] REG_TX_LWMARK              = 7'd1;
  localparam logic [6:0] REG_PAUSE_FRAME_SEND_EN    = 7'd2;
  localparam logic [6:0] REG_PAUSE_QUANTA_SET       = 7'd3;
  localparam logic [6:0] REG_IFGSET                 = 7'd4;
  localparam logic [6:0] REG_FULLDUPLEX             = 7'd5;
  localparam logic [6:0] REG_MAXRETRY               = 7'd6;
  localparam logic [6:0] REG_MAC_TX_ADD_EN          = 7'd7;
  localparam logic [6:0] REG_MAC_TX_ADD_PROM_DATA   = 7'd8;
  localparam logic [6:0] REG_MAC_TX_ADD_PROM_ADD    = 7'd9;
  localparam logic [6:0] REG_MAC_TX_ADD_PROM_WR     = 7'd10;
  localparam logic [6:0] REG_TX_PAUSE_EN            = 7'd11;
  localparam logic [6:0] REG_XOFF_CPU               = 7'd12;
  localparam logic [6:0] REG_XON_CPU                = 7'd13;
  localparam logic [6:0] REG_MAC_RX_ADD_CHK_EN      = 7'd14;
  localparam logic [6:0] REG_MAC_RX_ADD_PROM_DATA   = 7'd15;
  localparam logic [6:0] REG_MAC_RX_ADD_PROM_ADD    = 7'd16;
  localparam logic [6:0] REG_MAC_RX_ADD_PROM_WR     = 7'd17;
  localparam logic [6:0] REG_BROADCAST_FILTER_EN    = 7'd18;
  localparam logic [6:0] REG_BROADCAST_BUCKET_DEPTH = 7'd19;
  localparam logic [6:0] REG_BROADCAST_BUCKET_INTV  = 7'd20;
  localparam logic [6:0] REG_RX_APPEND_CRC          = 7'd21;
  localparam logic [6:0] REG_RX_HWMARK              = 7'd22;
  localparam logic [6:0] REG_RX_LWMARK              = 7'd23;
  localparam logic [6:0] REG_CRC_CHK_EN             = 7'd24;
  localparam logic [6:0] REG_RX_IFG_SET             = 7'd25;
  localparam logic [6:0] REG_RX_MAX_LENGTH          = 7'd26;
  localparam logic [6:0] REG_RX_MIN_LENGTH          = 7'd27;
  localparam logic [6:0] REG_CPU_RD_ADDR            = 7'd28;
  localparam logic [6:0] REG_CPU_RD_APPLY           = 7'd29;
  localparam logic [6:0] REG_CPU_RD_GRANT           = 7'd30;
  localparam logic [6:0] REG_CPU_RD_DOUT_L          = 7'd31;
  localparam logic [6:0] REG_CPU_RD_DOUT_H          = 7'd32;
  localparam logic [6:0] REG_LINE_LOOP_EN           = 7'd33;
  localparam logic [6:0] REG_SPEED                  = 7'd34;

  typedef enum logic [3:0] {
    INIT, IDLE, H_ACC, S_ADDR, S_APPLY,
    S_POLL, S_LO, S_HI, S_CLR, DONE
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } init_entry_t;

  localparam int INIT_LEN = 4;

  localparam init_entry_t INIT_TAB [INIT_LEN] = '{
    '{REG_PAUSE_FRAME_SEND_EN, 16'h0000},
    '{REG_BROADCAST_FILTER_EN, 16'h0000},
    '{REG_RX_APPEND_CRC,       16'h0000},
    '{REG_CRC_CHK_EN,          16'h0000}
  };

endpackage

// File: rtl/mac_reg_bus_port.sv
// Single two-cycle CPU register access: csb low for the cycle after start.
// done marks the csb-low cycle; read data is taken at the edge ending it.
module mac_reg_bus_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        csb,
  output logic        wrb,
  output logic [7:0]  ca,
  output logic [15:0] cd_in,
  input  logic [15:0] cd_out
);

  logic        csb_q;
  logic        wrb_q;
  logic [7:0]  ca_q;
  logic [15:0] cd_in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csb_q   <= 1'b1;
      wrb_q   <= 1'b1;
      ca_q    <= '0;
      cd_in_q <= '0;
    end else if (start) begin
      csb_q   <= 1'b0;
      wrb_q   <= ~we;
      ca_q    <= {addr, 1'b0};
      cd_in_q <= wdata;
    end else begin
      csb_q   <= 1'b1;
      wrb_q   <= 1'b1;
    end
  end

  assign done  = ~csb_q;
  assign rdata = cd_out;
  assign csb   = csb_q;
  assign wrb   = wrb_q;
  assign ca    = ca_q;
  assign cd_in = cd_in_q;

endmodule

// File: rtl/mac_reg_master.sv
// MAC CPU register bus master: init writes, host/stat round-robin, counter reads.
// Define MAC_REG_INIT_EN to replay the init write table after every reset.
module mac_reg_master
  import mac_reg_pkg::*;
#(
  parameter int POLL_MAX = 16
) (
  input  logic        clk_reg,
  input  logic        reset,
  output logic        csb,
  output logic        wrb,
  output logic [7:0]  ca,
  output logic [15:0] cd_in,
  input  logic [15:0] cd_out,
  output logic        init_done,
  output logic        busy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  input  logic        stat_req,
  input  logic [6:0]  stat_addr,
  output logic        stat_ack,
  output logic [31:0] stat_data,
  output logic        stat_err
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic          rr_q, rr_d;
  logic          hwe_q, hwe_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [15:0]   lo_q, lo_d;
  logic          host_ack_q, host_ack_d;
  logic [15:0]   host_rdata_q, host_rdata_d;
  logic          stat_ack_q, stat_ack_d;
  logic [31:0]   stat_data_q, stat_data_d;
  logic          stat_err_q, stat_err_d;
  logic          init_done_q, init_done_d;
  logic          busy_q;
`ifdef MAC_REG_INIT_EN
  logic [1:0]    idx_q, idx_d;
`endif

  logic          start, bus_we, bus_done;
  logic [6:0]    bus_addr;
  logic [15:0]   bus_wdata, bus_rdata;
  logic          acc_we;
  logic [6:0]    acc_addr;
  logic [15:0]   acc_wdata;
  logic          pick_stat;

  mac_reg_bus_port u_port (
    .clk    (clk_reg),
    .rst_n  (reset),
    .start  (start),
    .we     (bus_we),
    .addr   (bus_addr),
    .wdata  (bus_wdata),
    .done   (bus_done),
    .rdata  (bus_rdata),
    .csb    (csb),
    .wrb    (wrb),
    .ca     (ca),
    .cd_in  (cd_in),
    .cd_out (cd_out)
  );

  // Access issued from the phase-1 cycle of each sequenced state
  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = REG_CPU_RD_GRANT;
    acc_wdata = '0;
    unique case (state_q)
`ifdef MAC_REG_INIT_EN
      INIT: begin
        acc_we    = 1'b1;
        acc_addr  = INIT_TAB[idx_q].addr;
        acc_wdata = INIT_TAB[idx_q].data;
      end
`endif
      S_APPLY: begin
        acc_we    = 1'b1;
        acc_addr  = REG_CPU_RD_APPLY;
        acc_wdata = 16'd1;
      end
      S_LO:    acc_addr = REG_CPU_RD_DOUT_L;
      S_HI:    acc_addr = REG_CPU_RD_DOUT_H;
      S_CLR: begin
        acc_we    = 1'b1;
        acc_addr  = REG_CPU_RD_APPLY;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rr_d         = rr_q;
    hwe_d        = hwe_q;
    poll_d       = poll_q;
    lo_d         = lo_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    stat_ack_d   = 1'b0;
    stat_data_d  = stat_data_q;
    stat_err_d   = stat_err_q;
    init_done_d  = init_done_q;
`ifdef MAC_REG_INIT_EN
    idx_d        = idx_q;
`endif
    pick_stat    = 1'b0;
    start        = 1'b0;
    bus_we       = acc_we;
    bus_addr     = acc_addr;
    bus_wdata    = acc_wdata;
    unique case (state_q)
      IDLE: begin
        pick_stat = stat_req && (!host_req || rr_q);
        if (host_req || stat_req) begin
          start   = 1'b1;
          phase_d = 1'b0;
          rr_d    = !pick_stat;
          if (pick_stat) begin
            bus_we    = 1'b1;
            bus_addr  = REG_CPU_RD_ADDR;
            bus_wdata = {9'd0, stat_addr};
            state_d   = S_ADDR;
          end else begin
            bus_we    = host_we;
            bus_addr  = host_addr;
            bus_wdata = host_wdata;
            hwe_d     = host_we;
            state_d   = H_ACC;
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (phase_q) begin
          start   = 1'b1;
          phase_d = 1'b0;
        end else if (bus_done) begin
          phase_d = 1'b1;
          unique case (state_q)
`ifdef MAC_REG_INIT_EN
            INIT: begin
              if (idx_q == 2'(INIT_LEN - 1)) begin
                state_d     = IDLE;
                init_done_d = 1'b1;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end
`endif
            H_ACC: begin
              if (!hwe_q) host_rdata_d = bus_rdata;
              host_ack_d = 1'b1;
              state_d    = DONE;
            end
            S_ADDR:  state_d = S_APPLY;
            S_APPLY: begin
              poll_d  = '0;
              state_d = S_POLL;
            end
            S_POLL: begin
              poll_d = poll_q + PW'(1);
              if (bus_rdata[0]) begin
                state_d = S_LO;
              end else if (poll_q == PW'(POLL_MAX - 1)) begin
                stat_data_d = '0;
                stat_err_d  = 1'b1;
                state_d     = S_CLR;
              end
            end
            S_LO: begin
              lo_d    = bus_rdata;
              state_d = S_HI;
            end
            S_HI: begin
              stat_data_d = {bus_rdata, lo_q};
              stat_err_d  = 1'b0;
              state_d     = S_CLR;
            end
            S_CLR: begin
              stat_ack_d = 1'b1;
              state_d    = DONE;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_reg) begin
    if (!reset) begin
`ifdef MAC_REG_INIT_EN
      state_q     <= INIT;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      idx_q       <= '0;
`else
      state_q     <= IDLE;
      init_done_q <= 1'b1;
      busy_q      <= 1'b0;
`endif
      phase_q      <= 1'b1;
      rr_q         <= 1'b0;
      hwe_q        <= 1'b0;
      poll_q       <= '0;
      lo_q         <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      stat_ack_q   <= 1'b0;
      stat_data_q  <= '0;
      stat_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_done_q  <= init_done_d;
      busy_q       <= (state_d != IDLE);
`ifdef MAC_REG_INIT_EN
      idx_q        <= idx_d;
`endif
      phase_q      <= phase_d;
      rr_q         <= rr_d;
      hwe_q        <= hwe_d;
      poll_q       <= poll_d;
      lo_q         <= lo_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      stat_ack_q   <= stat_ack_d;
      stat_data_q  <= stat_data_d;
      stat_err_q   <= stat_err_d;
    end
  end

  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign stat_ack   = stat_ack_q;
  assign stat_data  = stat_data_q;
  assign stat_err   = stat_err_q;

endmodule

// File: tb/tb_mac_reg_master.sv
// Bench for mac_reg_master: MAC register model, bus monitor, scenario tasks.
// Honours MAC_REG_INIT_EN to match the build of the design under test.
module tb_mac_reg_master;

  localparam int PM = 4;

  logic        clk_reg = 1'b0;
  logic        reset = 1'b0;
  logic        csb, wrb;
  logic [7:0]  ca;
  logic [15:0] cd_in;
  logic [15:0] cd_out = '0;
  logic        init_done, busy;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        stat_req = 1'b0;
  logic [6:0]  stat_addr = '0;
  logic        stat_ack;
  logic [31:0] stat_data;
  logic        stat_err;

  always #5 clk_reg = ~clk_reg;

  mac_reg_master #(.POLL_MAX(PM)) dut (
    .clk_reg(clk_reg), .reset(reset),
    .csb(csb), .wrb(wrb), .ca(ca), .cd_in(cd_in), .cd_out(cd_out),
    .init_done(init_done), .busy(busy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .stat_req(stat_req), .stat_addr(stat_addr), .stat_ack(stat_ack),
    .stat_data(stat_data), .stat_err(stat_err)
  );

  typedef struct {
    bit          we;
    logic [7:0]  ca;
    logic [15:0] d;
    int          cyc;
  } acc_t;

  typedef struct {
    bit          we;
    logic [6:0]  r;
    logic [15:0] d;
  } exp_t;

  acc_t        log_q[$];
  logic [15:0] mem [0:127];
  logic [15:0] lo_val = '0, hi_val = '0;
  logic [15:0] last_rd = '0;
  int          cyc = 0, polls = 0, grant_at = 0, mon_bad = 0;
  int          total = 0, bad = 0;
  bit          prev_low = 1'b0;
  bit          ptr_stat = 1'b0;

  // Bus monitor: logs each csb-low cycle, applies writes, checks spacing
  always @(posedge clk_reg) begin
    acc_t e;
    if (csb === 1'b0) begin
      if (prev_low) mon_bad++;
      e.we  = (wrb === 1'b0);
      e.ca  = ca;
      e.d   = e.we ? cd_in : cd_out;
      e.cyc = cyc;
      log_q.push_back(e);
      if (e.we) mem[ca[7:1]] = cd_in;
      else if (ca[7:1] == 7'd30) polls++;
    end else if (csb === 1'b1 && wrb !== 1'b1) begin
      mon_bad++;
    end
    prev_low = (csb === 1'b0);
    cyc++;
  end

  // MAC read-data model
  always @(negedge clk_reg) begin
    if (ca[7:1] == 7'd30)
      cd_out = {15'd0, (grant_at != 0 && polls + 1 >= grant_at)};
    else if (ca[7:1] == 7'd31) cd_out = lo_val;
    else if (ca[7:1] == 7'd32) cd_out = hi_val;
    else cd_out = mem[ca[7:1]];
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk_reg);
    total++;
    if ({csb, wrb} !== 2'b11) begin
      bad++; $display("FAIL rst_bus: csb,wrb=%b want 11", {csb, wrb});
    end
    total++;
    if (ca !== 8'h00 || cd_in !== 16'h0000) begin
      bad++; $display("FAIL rst_ca: ca=%h cd_in=%h want 0", ca, cd_in);
    end
    total++;
    if ({host_ack, stat_ack, stat_err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags: %b want 000", {host_ack, stat_ack, stat_err});
    end
    total++;
    if (host_rdata !== 16'h0 || stat_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_data: %h %h want 0", host_rdata, stat_data);
    end
    total++;
`ifdef MAC_REG_INIT_EN
    if ({init_done, busy} !== 2'b01) begin
      bad++; $display("FAIL rst_status: %b want 01", {init_done, busy});
    end
`else
    if ({init_done, busy} !== 2'b10) begin
      bad++; $display("FAIL rst_status: %b want 10", {init_done, busy});
    end
`endif
  endtask

  // Releases reset at the current negedge and checks the init replay
  task automatic test_init();
    int c;
    bit ok;
    logic [7:0] exp_ca [4];
    exp_ca = '{8'h04, 8'h24, 8'h2A, 8'h30};
    log_q.delete();
    reset = 1'b1;
    c = cyc;
    ptr_stat = 1'b0;
    last_rd = '0;
`ifdef MAC_REG_INIT_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_reg);
      if (cyc == c + 7) begin
        total++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL init_c7: done=%b busy=%b want 0 1", init_done, busy);
        end
      end
      if (cyc == c + 8) begin
        total++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL init_c8: done=%b busy=%b want 1 0", init_done, busy);
        end
      end
    end
    ok = (log_q.size() == 4);
    for (int i = 0; i < 4 && ok; i++)
      ok = log_q[i].we && log_q[i].ca == exp_ca[i] &&
           log_q[i].d == 16'h0 && log_q[i].cyc == c + 1 + 2 * i;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL init_seq: %0d accesses, want 4 writes ca 04/24/2A/30 data 0",
               log_q.size());
    end
`else
    @(negedge clk_reg);
    total++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL noinit: done=%b busy=%b want 1 0", init_done, busy);
    end
    total++;
    if (log_q.size() != 0) begin
      bad++; $display("FAIL noinit_bus: %0d accesses want 0", log_q.size());
    end
`endif
  endtask

  task automatic host_txn(input bit we, input logic [6:0] a,
                          input logic [15:0] d);
    int c0, cack;
    bit got;
    logic [15:0] exp_rd;
    exp_rd = mem[a];
    log_q.delete();
    @(negedge clk_reg);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    c0 = cyc; got = 1'b0; cack = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_reg);
      if (host_ack === 1'b1) begin got = 1'b1; cack = cyc; end
    end
    host_req = 1'b0;
    ptr_stat = 1'b1;
    total++;
    if (!got) begin
      bad++; $display("FAIL host_ack: no ack within 50 cycles");
    end else begin
      total++;
      if (cack != c0 + 2) begin
        bad++; $display("FAIL host_lat: ack cycle %0d want %0d", cack, c0 + 2);
      end
      total++;
      if (log_q.size() != 1 || log_q[0].we != we ||
          log_q[0].ca !== {a, 1'b0} || log_q[0].cyc != c0 + 1 ||
          (we && log_q[0].d !== d)) begin
        bad++;
        $display("FAIL host_bus: %0d accesses, want one we=%b ca=%h at %0d",
                 log_q.size(), we, {a, 1'b0}, c0 + 1);
      end
      total++;
      if (!we) begin
        if (host_rdata !== exp_rd) begin
          bad++; $display("FAIL host_rdata: %h want %h", host_rdata, exp_rd);
        end
        last_rd = exp_rd;
      end else if (host_rdata !== last_rd) begin
        bad++; $display("FAIL host_hold: %h want %h", host_rdata, last_rd);
      end
    end
  endtask

  function automatic bit seq_ok(input exp_t ex[$], input int c0);
    if (log_q.size() != ex.size()) return 1'b0;
    for (int i = 0; i < ex.size(); i++) begin
      if (log_q[i].we != ex[i].we || log_q[i].ca !== {ex[i].r, 1'b0})
        return 1'b0;
      if (ex[i].we && log_q[i].d !== ex[i].d) return 1'b0;
      if (log_q[i].cyc != c0 + 1 + 2 * i) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void build_stat(output exp_t ex[$], input logic [6:0] a,
                                     input int g);
    int k;
    bit tmo;
    tmo = (g == 0 || g > PM);
    k = tmo ? PM : g;
    ex = {};
    ex.push_back('{1'b1, 7'd28, {9'd0, a}});
    ex.push_back('{1'b1, 7'd29, 16'd1});
    for (int i = 0; i < k; i++) ex.push_back('{1'b0, 7'd30, 16'd0});
    if (!tmo) begin
      ex.push_back('{1'b0, 7'd31, 16'd0});
      ex.push_back('{1'b0, 7'd32, 16'd0});
    end
    ex.push_back('{1'b1, 7'd29, 16'd0});
  endfunction

  task automatic stat_txn(input logic [6:0] a, input int g,
                          input logic [15:0] lo, input logic [15:0] hi);
    int c0, cack, lat;
    bit got, tmo;
    exp_t ex[$];
    logic [31:0] exp_data;
    tmo = (g == 0 || g > PM);
    lat = tmo ? 2 * (3 + PM) : 2 * (5 + g);
    exp_data = tmo ? 32'h0 : {hi, lo};
    build_stat(ex, a, g);
    log_q.delete();
    @(negedge clk_reg);
    grant_at = g; polls = 0; lo_val = lo; hi_val = hi;
    stat_req = 1'b1; stat_addr = a;
    c0 = cyc; got = 1'b0; cack = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_reg);
      if (stat_ack === 1'b1) begin got = 1'b1; cack = cyc; end
    end
    stat_req = 1'b0;
    ptr_stat = 1'b0;
    total++;
    if (!got) begin
      bad++; $display("FAIL stat_ack: no ack within 100 cycles");
    end else begin
      total++;
      if (cack != c0 + lat) begin
        bad++; $display("FAIL stat_lat: ack cycle %0d want %0d", cack, c0 + lat);
      end
      total++;
      if (stat_data !== exp_data || stat_err !== tmo) begin
        bad++;
        $display("FAIL stat_result: data=%h err=%b want %h %b",
                 stat_data, stat_err, exp_data, tmo);
      end
      total++;
      if (!seq_ok(ex, c0)) begin
        bad++;
        $display("FAIL stat_seq: %0d accesses want %0d in order", log_q.size(),
                 ex.size());
      end
    end
  endtask

  // Host write and stat read requested in the same cycle
  task automatic run_both();
    int c0, ch, cs, eh, es;
    bit sfirst;
    logic [6:0]  ha;
    logic [15:0] hd, lo, hi;
    ha = 7'($urandom_range(27, 0));
    hd = 16'($urandom);
    lo = 16'($urandom);
    hi = 16'($urandom);
    sfirst = ptr_stat;
    eh = sfirst ? 13 + 2 : 2;
    es = sfirst ? 12 : 3 + 12;
    ch = -1; cs = -1;
    log_q.delete();
    @(negedge clk_reg);
    grant_at = 1; polls = 0; lo_val = lo; hi_val = hi;
    host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd;
    stat_req = 1'b1; stat_addr = 7'h03;
    c0 = cyc;
    for (int i = 0; i < 80 && (ch < 0 || cs < 0); i++) begin
      @(negedge clk_reg);
      if (host_ack === 1'b1 && ch < 0) begin ch = cyc; host_req = 1'b0; end
      if (stat_ack === 1'b1 && cs < 0) begin cs = cyc; stat_req = 1'b0; end
    end
    host_req = 1'b0; stat_req = 1'b0;
    total++;
    if (ch < 0 || cs < 0) begin
      bad++; $display("FAIL arb_ack: host=%0d stat=%0d acks missing", ch, cs);
    end else begin
      total++;
      if (ch != c0 + eh || cs != c0 + es) begin
        bad++;
        $display("FAIL arb_order: host ack %0d stat ack %0d want %0d %0d",
                 ch - c0, cs - c0, eh, es);
      end
      total++;
      if (stat_data !== {hi, lo} || mem[ha] !== hd) begin
        bad++;
        $display("FAIL arb_data: stat=%h mem=%h want %h %h", stat_data,
                 mem[ha], {hi, lo}, hd);
      end
    end
  endtask

  task automatic test_arbitration();
    run_both();
    host_txn(1'b0, 7'd10, 16'h0);
    run_both();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(1, 0) == 1)
        host_txn(1'($urandom_range(1, 0)), 7'($urandom_range(27, 0)),
                 16'($urandom));
      else
        stat_txn(7'($urandom), int'($urandom_range(PM + 1, 0)),
                 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid_poll();
    bit seen;
    int acks;
    seen = 1'b0; acks = 0;
    log_q.delete();
    @(negedge clk_reg);
    grant_at = 0; polls = 0;
    stat_req = 1'b1; stat_addr = 7'h11;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_reg);
      if (polls > 0 && csb === 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL midpoll_reach: second poll not seen");
    end
    reset = 1'b0;
    stat_req = 1'b0;
    @(negedge clk_reg);
    total++;
    if (csb !== 1'b1 || wrb !== 1'b1) begin
      bad++; $display("FAIL midpoll_bus: csb=%b wrb=%b want 1 1", csb, wrb);
    end
    for (int i = 0; i < 3; i++) begin
      if (stat_ack !== 1'b0) acks++;
      @(negedge clk_reg);
    end
    total++;
    if (acks != 0) begin
      bad++; $display("FAIL midpoll_ack: %0d ack cycles want 0", acks);
    end
    test_init();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    test_reset();
    test_init();
    host_txn(1'b1, 7'd4, 16'h000C);
    mem[34] = 16'h0002;
    host_txn(1'b0, 7'd34, 16'h0);
    stat_txn(7'd5, 2, 16'hBEEF, 16'h1234);
    stat_txn(7'd9, 0, 16'h5555, 16'hAAAA);
    test_arbitration();
    test_random();
    test_reset_mid_poll();
    host_txn(1'b0, 7'd4, 16'h0);
    total++;
    if (mon_bad != 0) begin
      bad++; $display("FAIL bus_protocol: %0d violations want 0", mon_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
